// File: rtl/cci_mpf_shim_vtp_rsp_reorder_pkg.sv
// Shared VTP types for the lookup-response reorder buffer: request tags, page indices,
// service responses and the per-slot stored entry.
package cci_mpf_shim_vtp_rsp_reorder_pkg;

    localparam int unsigned CCI_MPF_SHIM_VTP_MAX_SVC_REQS = 16;
    localparam int unsigned CCI_PT_4KB_PA_PAGE_INDEX_BITS = 36;

    typedef logic [$clog2(CCI_MPF_SHIM_VTP_MAX_SVC_REQS)-1:0] t_cci_mpf_shim_vtp_req_tag;
    typedef logic [CCI_PT_4KB_PA_PAGE_INDEX_BITS-1:0] t_tlb_4kb_pa_page_idx;

    typedef struct packed {
        t_tlb_4kb_pa_page_idx      pagePA;
        logic                      error;
        t_cci_mpf_shim_vtp_req_tag tag;
        logic                      isBigPage;
    } t_cci_mpf_shim_vtp_lookup_rsp;

    typedef struct packed {
        t_tlb_4kb_pa_page_idx pagePA;
        logic                 error;
        logic                 isBigPage;
    } t_cci_mpf_shim_vtp_rob_entry;

endpackage

// File: rtl/cci_mpf_shim_vtp_rsp_reorder_if.sv
// Client-side connection of the VTP reorder buffer: tag allocation, service responses
// in, in-order translations out.
interface cci_mpf_shim_vtp_rsp_reorder_if
    import cci_mpf_shim_vtp_rsp_reorder_pkg::*;
#(
    parameter int unsigned N_ENTRIES   = CCI_MPF_SHIM_VTP_MAX_SVC_REQS,
    parameter int unsigned PA_IDX_BITS = CCI_PT_4KB_PA_PAGE_INDEX_BITS
) ();

    logic                         allocEn;
    logic                         allocRdy;
    logic [$clog2(N_ENTRIES)-1:0] allocTag;
    logic                         svcRspValid;
    t_cci_mpf_shim_vtp_lookup_rsp svcRsp;
    logic                         rspValid;
    logic [PA_IDX_BITS-1:0]       rspPagePA;
    logic                         rspError;
    logic                         rspIsBigPage;
    logic                         deqEn;
    logic [$clog2(N_ENTRIES):0]   numOutstanding;
    logic                         protocolErr;

    modport slave (
        input  allocEn, svcRspValid, svcRsp, deqEn,
        output allocRdy, allocTag, rspValid, rspPagePA, rspError, rspIsBigPage,
               numOutstanding, protocolErr
    );

    modport master (
        output allocEn, svcRspValid, svcRsp, deqEn,
        input  allocRdy, allocTag, rspValid, rspPagePA, rspError, rspIsBigPage,
               numOutstanding, protocolErr
    );

endinterface

// File: rtl/cci_mpf_shim_vtp_rsp_reorder_lutram.sv
// Small LUTRAM-style array: one synchronous write port, one asynchronous read port.
// Contents are not reset.
module cci_mpf_shim_vtp_rsp_reorder_lutram #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 1
) (
    input  logic                     clk_i,
    input  logic                     wen_i,
    input  logic [$clog2(Depth)-1:0] waddr_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic [$clog2(Depth)-1:0] raddr_i,
    output logic [Width-1:0]         rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (wen_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cci_mpf_shim_vtp_rsp_reorder.sv
// Reorder buffer for VTP lookups: hands out tags, absorbs out-of-order responses keyed by
// tag and releases translations strictly in allocation order.
module cci_mpf_shim_vtp_rsp_reorder
    import cci_mpf_shim_vtp_rsp_reorder_pkg::*;
#(
    parameter int unsigned N_ENTRIES   = CCI_MPF_SHIM_VTP_MAX_SVC_REQS,
    parameter int unsigned PA_IDX_BITS = CCI_PT_4KB_PA_PAGE_INDEX_BITS
) (
    input  logic                           clk,
    input  logic                           reset,
    cci_mpf_shim_vtp_rsp_reorder_if.slave  rr
);

    localparam int unsigned    IdxBits   = $clog2(N_ENTRIES);
    localparam logic [IdxBits:0] CountFull = (IdxBits + 1)'(N_ENTRIES);

    if (N_ENTRIES != CCI_MPF_SHIM_VTP_MAX_SVC_REQS ||
        (N_ENTRIES & (N_ENTRIES - 1)) != 0 ||
        PA_IDX_BITS != CCI_PT_4KB_PA_PAGE_INDEX_BITS) begin : g_bad_params
        $error("N_ENTRIES/PA_IDX_BITS must match the shared VTP package");
    end

    logic [IdxBits-1:0]   alloc_ptr_q, alloc_ptr_d;
    logic [IdxBits-1:0]   head_ptr_q, head_ptr_d;
    logic [IdxBits:0]     count_q, count_d;
    logic [N_ENTRIES-1:0] allocated_q, allocated_d;
    logic [N_ENTRIES-1:0] done_q, done_d;
    logic                 protocol_err_q, protocol_err_d;

    logic                        alloc_rdy, alloc_ok, rsp_valid, deq_ok, wr_ok;
    logic [IdxBits-1:0]          wr_tag;
    t_cci_mpf_shim_vtp_rob_entry wr_entry, head_entry;

    assign wr_tag   = rr.svcRsp.tag;
    assign wr_entry = '{pagePA:    rr.svcRsp.pagePA,
                        error:     rr.svcRsp.error,
                        isBigPage: rr.svcRsp.isBigPage};

    always_comb begin
        alloc_rdy = (count_q != CountFull);
        alloc_ok  = rr.allocEn && alloc_rdy;
        rsp_valid = allocated_q[head_ptr_q] && done_q[head_ptr_q];
        deq_ok    = rr.deqEn && rsp_valid;
        // A slot being allocated is always free, so a same-cycle write to it fails here too.
        wr_ok     = rr.svcRspValid && allocated_q[wr_tag] && !done_q[wr_tag];

        alloc_ptr_d    = alloc_ptr_q;
        head_ptr_d     = head_ptr_q;
        allocated_d    = allocated_q;
        done_d         = done_q;
        protocol_err_d = protocol_err_q | (rr.svcRspValid && !wr_ok);

        if (deq_ok) begin
            allocated_d[head_ptr_q] = 1'b0;
            done_d[head_ptr_q]      = 1'b0;
            head_ptr_d              = head_ptr_q + 1'b1;
        end
        if (wr_ok) begin
            done_d[wr_tag] = 1'b1;
        end
        if (alloc_ok) begin
            allocated_d[alloc_ptr_q] = 1'b1;
            done_d[alloc_ptr_q]      = 1'b0;
            alloc_ptr_d              = alloc_ptr_q + 1'b1;
        end

        count_d = count_q;
        if (alloc_ok && !deq_ok) begin
            count_d = count_q + 1'b1;
        end else if (!alloc_ok && deq_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_ptr_q    <= '0;
            head_ptr_q     <= '0;
            count_q        <= '0;
            allocated_q    <= '0;
            done_q         <= '0;
            // Nothing is allocated during reset, so any response seen now is stale.
            protocol_err_q <= rr.svcRspValid;
        end else begin
            alloc_ptr_q    <= alloc_ptr_d;
            head_ptr_q     <= head_ptr_d;
            count_q        <= count_d;
            allocated_q    <= allocated_d;
            done_q         <= done_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    cci_mpf_shim_vtp_rsp_reorder_lutram #(
        .Depth (N_ENTRIES),
        .Width ($bits(t_cci_mpf_shim_vtp_rob_entry))
    ) u_data (
        .clk_i   (clk),
        .wen_i   (wr_ok),
        .waddr_i (wr_tag),
        .wdata_i (wr_entry),
        .raddr_i (head_ptr_q),
        .rdata_o (head_entry)
    );

    assign rr.allocRdy       = alloc_rdy;
    assign rr.allocTag       = alloc_ptr_q;
    assign rr.rspValid       = rsp_valid;
    assign rr.rspPagePA      = head_entry.pagePA;
    assign rr.rspError       = head_entry.error;
    assign rr.rspIsBigPage   = head_entry.isBigPage;
    assign rr.numOutstanding = count_q;
    assign rr.protocolErr    = protocol_err_q;

    a_alloc_legal: assert property (@(posedge clk) disable iff (reset)
        !(rr.allocEn && !alloc_rdy));
    a_deq_legal: assert property (@(posedge clk) disable iff (reset)
        !(rr.deqEn && !rsp_valid));

endmodule

// File: tb/tb_cci_mpf_shim_vtp_rsp_reorder.sv
// Scoreboard bench for the VTP response reorder buffer: expected translations are queued at
// allocation and compared when the head entry is dequeued.
module tb_cci_mpf_shim_vtp_rsp_reorder;
    import cci_mpf_shim_vtp_rsp_reorder_pkg::*;

    localparam int unsigned N       = CCI_MPF_SHIM_VTP_MAX_SVC_REQS;
    localparam int unsigned PaBits  = CCI_PT_4KB_PA_PAGE_INDEX_BITS;
    localparam int unsigned TagBits = $clog2(N);

    typedef struct packed {
        logic [PaBits-1:0] pa;
        logic              err;
        logic              big;
    } sb_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    sb_t                sb_q[$];
    sb_t                tag_data[N];
    logic [TagBits-1:0] model_tag = '0;

    always #5 clk = ~clk;

    cci_mpf_shim_vtp_rsp_reorder_if #(.N_ENTRIES(N), .PA_IDX_BITS(PaBits)) rr ();

    cci_mpf_shim_vtp_rsp_reorder #(.N_ENTRIES(N), .PA_IDX_BITS(PaBits)) dut (
        .clk   (clk),
        .reset (reset),
        .rr    (rr)
    );

    function automatic sb_t mk(input logic [PaBits-1:0] pa, input logic e, input logic b);
        sb_t s;
        s.pa  = pa;
        s.err = e;
        s.big = b;
        return s;
    endfunction

    function automatic sb_t obs_head();
        return mk(rr.rspPagePA, rr.rspError, rr.rspIsBigPage);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        rr.allocEn     = 1'b0;
        rr.svcRspValid = 1'b0;
        rr.deqEn       = 1'b0;
        rr.svcRsp      = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb_q.delete();
        model_tag = '0;
    endtask

    task automatic set_alloc(input sb_t d);
        rr.allocEn          = 1'b1;
        tag_data[model_tag] = d;
        sb_q.push_back(d);
        model_tag = model_tag + 1'b1;
    endtask

    task automatic set_rsp_raw(input logic [TagBits-1:0] t, input sb_t d);
        rr.svcRspValid      = 1'b1;
        rr.svcRsp.tag       = t;
        rr.svcRsp.pagePA    = d.pa;
        rr.svcRsp.error     = d.err;
        rr.svcRsp.isBigPage = d.big;
    endtask

    task automatic set_rsp(input logic [TagBits-1:0] t);
        set_rsp_raw(t, tag_data[t]);
    endtask

    task automatic set_deq();
        rr.deqEn = 1'b1;
        void'(sb_q.pop_front());
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (rr.allocRdy !== 1'b1) begin
            n_fail++; $display("FAIL reset_allocRdy: got %b want 1", rr.allocRdy);
        end
        n_checks++;
        if (rr.allocTag !== '0) begin
            n_fail++; $display("FAIL reset_allocTag: got %0d want 0", rr.allocTag);
        end
        n_checks++;
        if (rr.rspValid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rspValid: got %b want 0", rr.rspValid);
        end
        n_checks++;
        if (rr.numOutstanding !== '0) begin
            n_fail++; $display("FAIL reset_numOutstanding: got %0d want 0", rr.numOutstanding);
        end
        n_checks++;
        if (rr.protocolErr !== 1'b0) begin
            n_fail++; $display("FAIL reset_protocolErr: got %b want 0", rr.protocolErr);
        end
    endtask

    task automatic test_in_order();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rr.allocTag !== TagBits'(i)) begin
                n_fail++; $display("FAIL inorder_tag: got %0d want %0d", rr.allocTag, i);
            end
            set_alloc(mk(PaBits'(32'h100 + i), 1'b0, 1'b0));
            step();
        end
        n_checks++;
        if (rr.numOutstanding !== 5'd4) begin
            n_fail++; $display("FAIL inorder_count: got %0d want 4", rr.numOutstanding);
        end
        for (int i = 0; i < 4; i++) begin
            set_rsp(TagBits'(i));
            step();
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rr.rspValid !== 1'b1 || obs_head() !== sb_q[0]) begin
                n_fail++;
                $display("FAIL inorder_data: got v=%b %h want v=1 %h",
                         rr.rspValid, obs_head(), sb_q[0]);
            end
            set_deq();
            step();
        end
        n_checks++;
        if (rr.numOutstanding !== '0 || rr.rspValid !== 1'b0) begin
            n_fail++;
            $display("FAIL inorder_drain: got cnt=%0d v=%b want 0 0",
                     rr.numOutstanding, rr.rspValid);
        end
    endtask

    task automatic test_reverse();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_alloc(mk(PaBits'(32'h200 + i), i[0], i[1]));
            step();
        end
        for (int t = 3; t >= 1; t--) begin
            set_rsp(TagBits'(t));
            step();
        end
        n_checks++;
        if (rr.rspValid !== 1'b0) begin
            n_fail++; $display("FAIL reverse_wait: got %b want 0", rr.rspValid);
        end
        set_rsp(TagBits'(0));
        n_checks++;
        if (rr.rspValid !== 1'b0) begin
            n_fail++; $display("FAIL reverse_no_bypass: got %b want 0", rr.rspValid);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rr.rspValid !== 1'b1 || obs_head() !== sb_q[0]) begin
                n_fail++;
                $display("FAIL reverse_data: got v=%b %h want v=1 %h",
                         rr.rspValid, obs_head(), sb_q[0]);
            end
            set_deq();
            step();
        end
        n_checks++;
        if (rr.rspValid !== 1'b0 || rr.numOutstanding !== '0) begin
            n_fail++;
            $display("FAIL reverse_drain: got v=%b cnt=%0d want 0 0",
                     rr.rspValid, rr.numOutstanding);
        end
    endtask

    task automatic test_full_wrap();
        logic [TagBits-1:0] pending[$];
        logic [N-1:0]       resp_done;
        logic [TagBits-1:0] head_tag, t;
        logic               exp_valid, do_deq, do_alloc;
        int                 total, idx;
        do_reset();
        resp_done = '0;
        for (int i = 0; i < N; i++) begin
            pending.push_back(TagBits'(i));
            set_alloc(mk(PaBits'($urandom), 1'($urandom), 1'($urandom)));
            step();
        end
        total = N;
        n_checks++;
        if (rr.allocRdy !== 1'b0 || rr.numOutstanding !== 5'(N)) begin
            n_fail++;
            $display("FAIL full_state: got rdy=%b cnt=%0d want 0 %0d",
                     rr.allocRdy, rr.numOutstanding, N);
        end
        pending.delete(0);
        set_rsp(TagBits'(0));
        step();
        n_checks++;
        if (rr.rspValid !== 1'b1 || obs_head() !== sb_q[0]) begin
            n_fail++;
            $display("FAIL full_head: got v=%b %h want v=1 %h", rr.rspValid, obs_head(), sb_q[0]);
        end
        set_deq();
        step();
        n_checks++;
        if (rr.allocRdy !== 1'b1 || rr.allocTag !== '0) begin
            n_fail++;
            $display("FAIL wrap_tag: got rdy=%b tag=%0d want 1 0", rr.allocRdy, rr.allocTag);
        end
        for (int cyc = 0; cyc < 2000 && (total < 40 || sb_q.size() != 0); cyc++) begin
            head_tag  = model_tag - TagBits'(sb_q.size());
            exp_valid = (sb_q.size() != 0) && resp_done[head_tag];
            n_checks++;
            if (rr.rspValid !== exp_valid || rr.allocRdy !== (sb_q.size() < N) ||
                rr.allocTag !== model_tag) begin
                n_fail++;
                $display("FAIL wrap_ctrl: got v=%b rdy=%b tag=%0d want %b %b %0d",
                         rr.rspValid, rr.allocRdy, rr.allocTag,
                         exp_valid, sb_q.size() < N, model_tag);
            end
            if (exp_valid) begin
                n_checks++;
                if (obs_head() !== sb_q[0]) begin
                    n_fail++; $display("FAIL wrap_data: got %h want %h", obs_head(), sb_q[0]);
                end
            end
            do_deq   = exp_valid && ($urandom_range(3) != 0);
            do_alloc = (sb_q.size() < N) && (total < 40) && ($urandom_range(1) == 1);
            if (pending.size() != 0 && $urandom_range(1) == 1) begin
                idx = int'($urandom_range(pending.size() - 1));
                t   = pending[idx];
                pending.delete(idx);
                resp_done[t] = 1'b1;
                set_rsp(t);
            end
            if (do_deq) begin
                resp_done[head_tag] = 1'b0;
                set_deq();
            end
            if (do_alloc) begin
                pending.push_back(model_tag);
                set_alloc(mk(PaBits'($urandom), 1'($urandom), 1'($urandom)));
                total++;
            end
            step();
        end
        n_checks++;
        if (total < 40 || sb_q.size() != 0 || rr.numOutstanding !== '0) begin
            n_fail++;
            $display("FAIL wrap_timeout: got total=%0d left=%0d cnt=%0d want 40 0 0",
                     total, sb_q.size(), rr.numOutstanding);
        end
    endtask

    task automatic test_simul();
        logic [TagBits-1:0] prev_tag;
        logic               have_prev;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_alloc(mk(PaBits'(32'h300 + i), 1'b0, 1'b1));
            step();
        end
        for (int i = 0; i < 8; i++) begin
            set_rsp(TagBits'(i));
            step();
        end
        have_prev = 1'b0;
        prev_tag  = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            n_checks++;
            if (rr.numOutstanding !== 5'd8 || rr.allocTag !== model_tag) begin
                n_fail++;
                $display("FAIL simul_count: got cnt=%0d tag=%0d want 8 %0d",
                         rr.numOutstanding, rr.allocTag, model_tag);
            end
            n_checks++;
            if (rr.rspValid !== 1'b1 || obs_head() !== sb_q[0]) begin
                n_fail++;
                $display("FAIL simul_data: got v=%b %h want v=1 %h",
                         rr.rspValid, obs_head(), sb_q[0]);
            end
            if (have_prev) begin
                set_rsp(prev_tag);
            end
            prev_tag  = model_tag;
            have_prev = 1'b1;
            set_deq();
            set_alloc(mk(PaBits'(32'h400 + cyc), cyc[0], 1'b0));
            step();
        end
        n_checks++;
        if (rr.numOutstanding !== 5'd8 || rr.allocTag !== TagBits'(28)) begin
            n_fail++;
            $display("FAIL simul_end: got cnt=%0d tag=%0d want 8 12",
                     rr.numOutstanding, rr.allocTag);
        end
    endtask

    task automatic test_protocol();
        do_reset();
        set_alloc(mk(PaBits'(32'h500), 1'b0, 1'b0));
        step();
        set_alloc(mk(PaBits'(32'h501), 1'b1, 1'b1));
        step();
        set_rsp(TagBits'(0));
        step();
        n_checks++;
        if (rr.protocolErr !== 1'b0) begin
            n_fail++; $display("FAIL proto_clean: got %b want 0", rr.protocolErr);
        end
        set_rsp_raw(TagBits'(5), mk(PaBits'(32'hBAD), 1'b1, 1'b1));
        step();
        n_checks++;
        if (rr.protocolErr !== 1'b1 || rr.numOutstanding !== 5'd2 || rr.allocTag !== 4'd2) begin
            n_fail++;
            $display("FAIL proto_unalloc: got err=%b cnt=%0d tag=%0d want 1 2 2",
                     rr.protocolErr, rr.numOutstanding, rr.allocTag);
        end
        set_rsp_raw(TagBits'(0), mk(PaBits'(32'hDEAD), 1'b1, 1'b0));
        step();
        n_checks++;
        if (rr.rspValid !== 1'b1 || obs_head() !== sb_q[0] || rr.protocolErr !== 1'b1) begin
            n_fail++;
            $display("FAIL proto_dup: got v=%b %h err=%b want v=1 %h err=1",
                     rr.rspValid, obs_head(), rr.protocolErr, sb_q[0]);
        end
        set_deq();
        step();
        n_checks++;
        if (rr.rspValid !== 1'b0) begin
            n_fail++; $display("FAIL proto_tag1_pending: got %b want 0", rr.rspValid);
        end
        set_rsp(TagBits'(1));
        step();
        n_checks++;
        if (rr.rspValid !== 1'b1 || obs_head() !== sb_q[0]) begin
            n_fail++;
            $display("FAIL proto_tag1: got v=%b %h want v=1 %h", rr.rspValid, obs_head(), sb_q[0]);
        end
        set_deq();
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_alloc(mk(PaBits'(32'h600 + i), 1'b0, 1'b0));
            step();
        end
        for (int i = 0; i < 3; i++) begin
            set_rsp(TagBits'(i));
            step();
        end
        n_checks++;
        if (rr.rspValid !== 1'b1 || rr.numOutstanding !== 5'd6) begin
            n_fail++;
            $display("FAIL midrst_before: got v=%b cnt=%0d want 1 6",
                     rr.rspValid, rr.numOutstanding);
        end
        do_reset();
        n_checks++;
        if (rr.rspValid !== 1'b0 || rr.allocTag !== '0 || rr.numOutstanding !== '0) begin
            n_fail++;
            $display("FAIL midrst_after: got v=%b tag=%0d cnt=%0d want 0 0 0",
                     rr.rspValid, rr.allocTag, rr.numOutstanding);
        end
        set_rsp_raw(TagBits'(4), mk(PaBits'(32'h604), 1'b0, 1'b0));
        step();
        n_checks++;
        if (rr.protocolErr !== 1'b1 || rr.rspValid !== 1'b0 || rr.numOutstanding !== '0) begin
            n_fail++;
            $display("FAIL midrst_stale: got err=%b v=%b cnt=%0d want 1 0 0",
                     rr.protocolErr, rr.rspValid, rr.numOutstanding);
        end
    endtask

    initial begin
        rr.allocEn     = 1'b0;
        rr.svcRspValid = 1'b0;
        rr.deqEn       = 1'b0;
        rr.svcRsp      = '0;
        test_reset();
        test_in_order();
        test_reverse();
        test_full_wrap();
        test_simul();
        test_protocol();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
